cordic_vec_sched: RTL

Scheduler that time-shares the 18-stage pipelined CORDIC vectoring unit between two sample sources: channel 0 (voltage I/Q) and channel 1 (current I/Q). It does four things:
- Arbitrates the two sources round-robin and issues at most one vector per cycle.
- Pre-rotates left-half-plane vectors so the CORDIC sees only x ≥ 0.
- Tracks in-flight samples with a tag pipeline, because the CORDIC has no valid or tag path of its own.
- Demultiplexes the quadrant-corrected angle/magnitude results back to the owning channel.

It sits between the I/Q demodulator outputs and the impedance computation logic.

---
 rtl/cordic_vec_sched.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/cordic_vec_sched.sv
// Round-robin scheduler sharing one pipelined CORDIC vectoring unit between two I/Q channels.
// Optional phase-difference output is enabled by defining CORDIC_SCHED_PHASE_DIFF_EN.
module cordic_vec_sched #(
    parameter int CORDIC_LAT = 18
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [15:0] req_x0,
    input  logic [15:0] req_y0,
    input  logic [15:0] req_x1,
    input  logic [15:0] req_y1,
    output logic [31:0] cordic_x,
    output logic [31:0] cordic_y,
    output logic        cordic_start,
    input  logic [31:0] cordic_angle,
    input  logic [31:0] cordic_mozhi,
    output logic        res_valid,
    output logic        res_ch,
    output logic [31:0] res_angle,
    output logic [31:0] res_mag,
    output logic [4:0]  inflight
`ifdef CORDIC_SCHED_PHASE_DIFF_EN
    ,
    output logic        pd_valid,
    output logic [31:0] pd
`endif
);

    function automatic logic signed [15:0] clamp16(input logic signed [15:0] v);
        return (v == 16'sh8000) ? 16'sh8001 : v;
    endfunction

    function automatic logic signed [31:0] unflip(input logic signed [31:0] a, input logic f);
        if (!f)
            return a;
        return (a <= 32'sd0) ? a + 32'sd180 : a - 32'sd180;
    endfunction

    logic                  rr;
    logic                  hs;
    logic                  gnt_ch;
    logic signed [15:0]    sel_x, sel_y, cx, cy;
    logic signed [31:0]    ex, ey;
    logic                  flip_in;
    logic signed [31:0]    ang_in;
    logic [CORDIC_LAT:0]   vld_p, ch_p, flip_p;

    always_comb begin
        req_ready = 2'b00;
        if (en) begin
            case (req_valid)
                2'b01:   req_ready = 2'b01;
                2'b10:   req_ready = 2'b10;
                2'b11:   req_ready = rr ? 2'b10 : 2'b01;
                default: req_ready = 2'b00;
            endcase
        end
    end

    assign hs     = |(req_valid & req_ready);
    assign gnt_ch = req_ready[1];

    // Left-half-plane vectors are rotated by 180 degrees so the CORDIC only sees x >= 0
    always_comb begin
        sel_x   = gnt_ch ? req_x1 : req_x0;
        sel_y   = gnt_ch ? req_y1 : req_y0;
        cx      = clamp16(sel_x);
        cy      = clamp16(sel_y);
        flip_in = cx[15];
        ex      = {{16{cx[15]}}, cx};
        ey      = {{16{cy[15]}}, cy};
    end

    // Issue stage: arbiter pointer, CORDIC operands, sticky start
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr           <= 1'b0;
            cordic_start <= 1'b0;
            cordic_x     <= '0;
            cordic_y     <= '0;
        end else if (hs) begin
            rr           <= ~gnt_ch;
            cordic_start <= 1'b1;
            cordic_x     <= flip_in ? -ex : ex;
            cordic_y     <= flip_in ? -ey : ey;
        end
    end

    // Tag pipeline: mirrors the CORDIC latency, never stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p  <= '0;
            ch_p   <= '0;
            flip_p <= '0;
        end else begin
            vld_p  <= {vld_p[CORDIC_LAT-1:0], hs};
            ch_p   <= {ch_p[CORDIC_LAT-1:0], gnt_ch};
            flip_p <= {flip_p[CORDIC_LAT-1:0], flip_in};
        end
    end

    assign ang_in = cordic_angle;

    // Output stage: quadrant correction and demux tag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_ch    <= 1'b0;
            res_angle <= '0;
            res_mag   <= '0;
        end else begin
            res_valid <= vld_p[CORDIC_LAT];
            if (vld_p[CORDIC_LAT]) begin
                res_ch    <= ch_p[CORDIC_LAT];
                res_angle <= unflip(ang_in, flip_p[CORDIC_LAT]);
                res_mag   <= cordic_mozhi;
            end
        end
    end

    // Decrement on the edge that raises res_valid, so the count peaks at CORDIC_LAT+1
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            inflight <= '0;
        else begin
            case ({hs, vld_p[CORDIC_LAT]})
                2'b10:   inflight <= inflight + 5'd1;
                2'b01:   inflight <= inflight - 5'd1;
                default: inflight <= inflight;
            endcase
        end
    end

`ifdef CORDIC_SCHED_PHASE_DIFF_EN
    function automatic logic signed [31:0] wrap180(input logic signed [31:0] d);
        if (d > 32'sd180)
            return d - 32'sd360;
        if (d <= -32'sd180)
            return d + 32'sd360;
        return d;
    endfunction

    logic signed [31:0] hold_angle;
    logic               hold_vld;

    // Phase-difference stage: channel-0 angle held until a channel-1 result pairs with it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_angle <= '0;
            hold_vld   <= 1'b0;
            pd_valid   <= 1'b0;
            pd         <= '0;
        end else begin
            pd_valid <= res_valid && res_ch && hold_vld;
            if (res_valid && !res_ch) begin
                hold_angle <= res_angle;
                hold_vld   <= 1'b1;
            end
            if (res_valid && res_ch && hold_vld)
                pd <= wrap180(hold_angle - $signed(res_angle));
        end
    end
`endif

endmodule
